// File: rtl/iob_uart16550_wb_driver.sv
// iob_uart16550_wb_driver
// Wishbone initiator that owns one iob_uart16550. After reset it programs the
// line control, divisor latch and interrupt enable registers, then polls LSR
// and moves bytes between the RBR/THR registers and valid/ready streams.
// One transaction at a time: cyc/stb rise together, drop the cycle after ack,
// and stay low for at least one cycle before the next request.
// Optional ack watchdog: define IOB_UART16550_WB_DRIVER_TIMEOUT_EN.
module iob_uart16550_wb_driver #(
    parameter logic [15:0] DIV            = 16'd2,
    parameter logic [7:0]  LCR_VAL        = 8'h1B,
    parameter logic [7:0]  IER_VAL        = 8'h00,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        cke_i,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        init_done_o,
    output logic [7:0]  lsr_o,
    output logic        err_o
);

    localparam logic [2:0] CFG_LCR_DLAB = 3'd0;
    localparam logic [2:0] CFG_DL1      = 3'd1;
    localparam logic [2:0] CFG_DL2      = 3'd2;
    localparam logic [2:0] CFG_LCR      = 3'd3;
    localparam logic [2:0] CFG_IER      = 3'd4;
    localparam logic [2:0] RD_LSR       = 3'd5;
    localparam logic [2:0] RD_RBR       = 3'd6;
    localparam logic [2:0] WR_THR       = 3'd7;

    // Pick the byte that sits in lane 'lane' of a 32-bit bus word.
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    // Place a byte into lane 'lane' of a 32-bit bus word, other lanes zero.
    function automatic logic [31:0] lane_place(input logic [7:0] b, input logic [1:0] lane);
        logic [31:0] w;
        case (lane)
            2'd0:    w = {24'h000000, b};
            2'd1:    w = {16'h0000, b, 8'h00};
            2'd2:    w = {8'h00, b, 16'h0000};
            2'd3:    w = {b, 24'h000000};
            default: w = {24'h000000, b};
        endcase
        return w;
    endfunction

    logic [2:0]  state_r;
    logic        cyc_r;
    logic [4:0]  adr_r;
    logic [31:0] dat_r;
    logic [3:0]  sel_r;
    logic        we_r;
    logic        tx_ready_r;
    logic [7:0]  rx_data_r;
    logic        rx_valid_r;
    logic        init_done_r;
    logic [7:0]  lsr_r;

    logic [4:0]  req_adr_s;
    logic [7:0]  req_byte_s;
    logic        req_we_s;
    logic [2:0]  next_state_s;
    logic [7:0]  rd_byte_s;
    logic        ack_s;
    logic        timeout_s;
    logic        done_s;

    assign ack_s     = cyc_r & wb_ack_i;
    assign done_s    = ack_s | timeout_s;
    assign rd_byte_s = lane_byte(wb_dat_i, adr_r[1:0]);

    // Register access requested by the current state.
    always_comb begin
        req_adr_s  = 5'd5;
        req_byte_s = 8'h00;
        req_we_s   = 1'b0;
        case (state_r)
            CFG_LCR_DLAB: begin req_adr_s = 5'd3; req_byte_s = LCR_VAL | 8'h80; req_we_s = 1'b1; end
            CFG_DL1:      begin req_adr_s = 5'd0; req_byte_s = DIV[7:0];        req_we_s = 1'b1; end
            CFG_DL2:      begin req_adr_s = 5'd1; req_byte_s = DIV[15:8];       req_we_s = 1'b1; end
            CFG_LCR:      begin req_adr_s = 5'd3; req_byte_s = LCR_VAL & 8'h7F; req_we_s = 1'b1; end
            CFG_IER:      begin req_adr_s = 5'd1; req_byte_s = IER_VAL;         req_we_s = 1'b1; end
            RD_LSR:       begin req_adr_s = 5'd5; req_byte_s = 8'h00;           req_we_s = 1'b0; end
            RD_RBR:       begin req_adr_s = 5'd0; req_byte_s = 8'h00;           req_we_s = 1'b0; end
            WR_THR:       begin req_adr_s = 5'd0; req_byte_s = tx_data_i;       req_we_s = 1'b1; end
            default:      begin req_adr_s = 5'd5; req_byte_s = 8'h00;           req_we_s = 1'b0; end
        endcase
    end

    // State after the current transaction completes; RX wins over TX so the
    // receive FIFO is drained before it can overrun.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            CFG_LCR_DLAB: next_state_s = CFG_DL1;
            CFG_DL1:      next_state_s = CFG_DL2;
            CFG_DL2:      next_state_s = CFG_LCR;
            CFG_LCR:      next_state_s = CFG_IER;
            CFG_IER:      next_state_s = RD_LSR;
            RD_LSR: begin
                if (ack_s && rd_byte_s[0] && !rx_valid_r) begin
                    next_state_s = RD_RBR;
                end else if (ack_s && rd_byte_s[5] && tx_valid_i) begin
                    next_state_s = WR_THR;
                end else begin
                    next_state_s = RD_LSR;
                end
            end
            RD_RBR:       next_state_s = RD_LSR;
            WR_THR:       next_state_s = RD_LSR;
            default:      next_state_s = CFG_LCR_DLAB;
        endcase
    end

    // Bus sequencing, FSM advance and stream handshakes.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_r     <= CFG_LCR_DLAB;
            cyc_r       <= 1'b0;
            adr_r       <= 5'd0;
            dat_r       <= 32'h0000_0000;
            sel_r       <= 4'b0000;
            we_r        <= 1'b0;
            tx_ready_r  <= 1'b0;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            init_done_r <= 1'b0;
            lsr_r       <= 8'h00;
        end else if (cke_i) begin
            tx_ready_r <= 1'b0;
            if (rx_valid_r && rx_ready_i) begin
                rx_valid_r <= 1'b0;
            end
            if (!cyc_r) begin
                cyc_r <= 1'b1;
                adr_r <= req_adr_s;
                dat_r <= lane_place(req_byte_s, req_adr_s[1:0]);
                sel_r <= 4'b0001 << req_adr_s[1:0];
                we_r  <= req_we_s;
            end else if (done_s) begin
                cyc_r   <= 1'b0;
                state_r <= next_state_s;
                if (state_r == CFG_IER) begin
                    init_done_r <= 1'b1;
                end
                if (ack_s) begin
                    case (state_r)
                        RD_LSR:  lsr_r <= rd_byte_s;
                        RD_RBR:  begin rx_data_r <= rd_byte_s; rx_valid_r <= 1'b1; end
                        WR_THR:  tx_ready_r <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef IOB_UART16550_WB_DRIVER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt_r;
    logic        err_r;

    assign timeout_s = cyc_r & ~wb_ack_i & (to_cnt_r == TO_LAST);
    assign err_o     = err_r;

    // Count cycles spent waiting for ack in the current transaction.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            to_cnt_r <= 16'd0;
        end else if (cke_i) begin
            if (cyc_r && !wb_ack_i && !timeout_s) begin
                to_cnt_r <= to_cnt_r + 16'd1;
            end else begin
                to_cnt_r <= 16'd0;
            end
        end
    end

    // Sticky error raised by any abandoned transaction.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            err_r <= 1'b0;
        end else if (cke_i && timeout_s) begin
            err_r <= 1'b1;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_s = 1'b0;
    assign err_o     = 1'b0;
`endif

    assign wb_adr_o    = adr_r;
    assign wb_dat_o    = dat_r;
    assign wb_sel_o    = sel_r;
    assign wb_we_o     = we_r;
    assign wb_cyc_o    = cyc_r;
    assign wb_stb_o    = cyc_r;
    assign tx_ready_o  = tx_ready_r;
    assign rx_data_o   = rx_data_r;
    assign rx_valid_o  = rx_valid_r;
    assign init_done_o = init_done_r;
    assign lsr_o       = lsr_r;

endmodule

// File: tb/tb_iob_uart16550_wb_driver.sv
// Bench for iob_uart16550_wb_driver: a behavioural UART register slave answers
// the bus; expected config writes, THR bytes and RX bytes are queued when the
// stimulus is issued and popped by monitors when the DUT presents them.
module tb_iob_uart16550_wb_driver;

    localparam int ACK_LAT = 2;
    localparam int TX_TIME = 20;

    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic        cke_i;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;
    logic [7:0]  tx_data_i;
    logic        tx_valid_i;
    logic        tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic        init_done_o;
    logic [7:0]  lsr_o;
    logic        err_o;

    iob_uart16550_wb_driver dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .init_done_o(init_done_o), .lsr_o(lsr_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] cfg_exp[$];
    logic [7:0]  tx_exp[$];
    logic [7:0]  rx_exp[$];
    logic [7:0]  rx_fifo[$];

    bit          thre_m = 1'b1;
    int          thre_cnt = 0;
    bit          last_lsr_thre = 1'b0;
    int          wait_cnt = 0;
    bit          lsr_pend = 1'b0;
    logic [7:0]  lsr_pend_val = 8'h00;
    int          tx_pulses = 0;
    int          tx_sent = 0;
    bit          tx_ready_prev = 1'b0;
    bit          cke_jitter = 1'b0;
    int          jit_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] get_lane(input logic [31:0] w, input logic [1:0] l);
        case (l)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    task automatic push_cfg();
        cfg_exp.push_back({5'd3, 8'h9B, 4'b1000});
        cfg_exp.push_back({5'd0, 8'h02, 4'b0001});
        cfg_exp.push_back({5'd1, 8'h00, 4'b0010});
        cfg_exp.push_back({5'd3, 8'h1B, 4'b1000});
        cfg_exp.push_back({5'd1, 8'h00, 4'b0010});
    endtask

    // Slave response and write/read bookkeeping for one acked transaction.
    task automatic serve();
        logic [7:0]  b;
        logic [7:0]  v;
        logic [16:0] e;
        b = get_lane(wb_dat_o, wb_adr_o[1:0]);
        wb_dat_i = 32'hA5A5_A5A5;
        if (wb_we_o) begin
            if (!init_done_o) begin
                check("lsr_pre_init", 32'(lsr_o), 32'h0);
                if (cfg_exp.size() == 0) begin
                    check("cfg_extra_write", 32'({wb_adr_o, b, wb_sel_o}), 32'h1FFFF);
                end else begin
                    e = cfg_exp.pop_front();
                    check("cfg_write", 32'({wb_adr_o, b, wb_sel_o}), 32'(e));
                end
            end else begin
                if (tx_exp.size() == 0) begin
                    check("thr_unexpected", 32'({wb_adr_o, b, wb_sel_o}), 32'h1FFFF);
                end else begin
                    check("thr_write", 32'({wb_adr_o, b, wb_sel_o}), 32'({5'd0, tx_exp.pop_front(), 4'b0001}));
                end
                check("thr_thre", 32'({last_lsr_thre, thre_m}), 32'h3);
                thre_m   = 1'b0;
                thre_cnt = TX_TIME;
            end
        end else begin
            v = 8'h00;
            if (wb_adr_o == 5'd5) begin
                v = {1'b0, thre_m, thre_m, 4'b0000, (rx_fifo.size() != 0)};
                last_lsr_thre = thre_m;
                lsr_pend      = 1'b1;
                lsr_pend_val  = v;
            end else if (wb_adr_o == 5'd0) begin
                check("rbr_gate", 32'(rx_valid_o), 32'h0);
                if (rx_fifo.size() == 0) begin
                    check("rbr_empty_read", 32'h1, 32'h0);
                end else begin
                    v = rx_fifo.pop_front();
                end
            end
            case (wb_adr_o[1:0])
                2'd0:    wb_dat_i[7:0]   = v;
                2'd1:    wb_dat_i[15:8]  = v;
                2'd2:    wb_dat_i[23:16] = v;
                default: wb_dat_i[31:24] = v;
            endcase
        end
    endtask

    // UART slave model: acks after ACK_LAT cycles, checks LSR capture.
    always @(negedge clk_i) begin
        if (lsr_pend && !wb_cyc_o) begin
            check("lsr_capture", 32'(lsr_o), 32'(lsr_pend_val));
            lsr_pend = 1'b0;
        end
        if (thre_cnt > 0) begin
            thre_cnt--;
            if (thre_cnt == 0) thre_m = 1'b1;
        end
        if (!(wb_cyc_o && wb_stb_o)) begin
            wb_ack_i = 1'b0;
            wait_cnt = 0;
        end else if (!wb_ack_i) begin
            wait_cnt++;
            if (wait_cnt >= ACK_LAT) begin
                wb_ack_i = 1'b1;
                serve();
            end
        end
    end

    // RX stream monitor and tx_ready pulse monitor.
    always @(negedge clk_i) begin
        if (rx_valid_o && rx_ready_i && cke_i) begin
            if (rx_exp.size() == 0) check("rx_unexpected", 32'(rx_data_o), 32'h1FF);
            else check("rx_byte", 32'(rx_data_o), 32'(rx_exp.pop_front()));
        end
        if (tx_ready_o) begin
            if (tx_ready_prev) check("tx_ready_width", 32'd2, 32'd1);
            else tx_pulses++;
        end
        tx_ready_prev = tx_ready_o;
    end

    // Clock-enable generator: gaps every fifth cycle while jitter is on.
    initial begin
        cke_i = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            jit_cnt++;
            cke_i = cke_jitter ? ((jit_cnt % 5) != 0) : 1'b1;
        end
    end

    task automatic wait_init();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk_i); #1;
            if (init_done_o) break;
        end
        check("init_done", 32'(init_done_o), 32'h1);
        check("cfg_all_written", 32'(cfg_exp.size()), 32'h0);
    endtask

    task automatic send_tx(input logic [7:0] b);
        bit seen;
        @(posedge clk_i); #1;
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        tx_exp.push_back(b);
        tx_sent++;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_i); #1;
            if (tx_ready_o) begin seen = 1'b1; break; end
        end
        if (!seen) check("tx_accept_timeout", 32'h0, 32'h1);
        tx_valid_i = 1'b0;
    endtask

    task automatic inject_rx(input logic [7:0] b);
        rx_fifo.push_back(b);
        rx_exp.push_back(b);
    endtask

    task automatic wait_rx_drain();
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk_i); #1;
            if (rx_exp.size() == 0 && rx_fifo.size() == 0) break;
        end
        check("rx_drain", 32'(rx_exp.size()), 32'h0);
    endtask

    initial begin
        bit found;
        arst_n_i   = 1'b0;
        wb_ack_i   = 1'b0;
        wb_dat_i   = 32'h0;
        tx_data_i  = 8'h00;
        tx_valid_i = 1'b0;
        rx_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_bus", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o}), 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_flags", 32'({tx_ready_o, rx_valid_o, init_done_o, err_o}), 32'h0);
        check("rst_bytes", 32'({rx_data_o, lsr_o}), 32'h0);

        // Configuration with clock-enable gaps
        push_cfg();
        cke_jitter = 1'b1;
        arst_n_i   = 1'b1;
        wait_init();
        cke_jitter = 1'b0;

        // Two bytes each way
        send_tx(8'h81);
        send_tx(8'h42);
        inject_rx(8'h81);
        inject_rx(8'h42);
        wait_rx_drain();

        // Consumer stalls: first byte held, second stays in the UART
        @(posedge clk_i); #1;
        rx_ready_i = 1'b0;
        inject_rx(8'h81);
        inject_rx(8'h42);
        repeat (300) @(posedge clk_i);
        #1;
        check("hold_valid", 32'(rx_valid_o), 32'h1);
        check("hold_data", 32'(rx_data_o), 32'h81);
        check("hold_uart_fifo", 32'(rx_fifo.size()), 32'h1);
        rx_ready_i = 1'b1;
        wait_rx_drain();

        // TX burst with interleaved RX traffic
        for (int i = 0; i < 20; i++) begin
            if (i == 5 || i == 12) inject_rx(8'(8'hC0 + i));
            send_tx(8'(8'h10 + 7 * i));
        end
        wait_rx_drain();
        check("tx_all_written", 32'(tx_exp.size()), 32'h0);

        // Reset while a THR write strobe is high
        @(posedge clk_i); #1;
        tx_data_i  = 8'hEE;
        tx_valid_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_i); #1;
            if (wb_stb_o && wb_we_o) begin found = 1'b1; break; end
        end
        check("abort_thr_seen", 32'(found), 32'h1);
        arst_n_i = 1'b0;
        #1;
        check("abort_bus_drop", 32'({wb_cyc_o, wb_stb_o, tx_ready_o, init_done_o}), 32'h0);
        tx_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        push_cfg();
        arst_n_i = 1'b1;
        wait_init();
        send_tx(8'h5A);

        repeat (50) @(posedge clk_i);
        #1;
        check("tx_pulse_count", 32'(tx_pulses), 32'(tx_sent));
        check("tx_queue_empty", 32'(tx_exp.size()), 32'h0);
        check("err_low", 32'(err_o), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
